// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a circular-buffer FIFO feeding a frame engine with
// configurable data width, parity and stop bits; queued frames leave back-to-back.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          busy,
    output logic                          txd
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [PTR_W:0]   DEPTH     = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] shift;
    logic [CNT_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_cnt;
    logic                 par_bit;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 frame_end;

    // full is taken from the registered count, so a same-cycle pop never frees room for a push.
    assign full      = (count == DEPTH);
    assign empty     = (count == '0);
    assign push      = wr_en && !full;
    assign head      = mem[rd_ptr];
    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign frame_end = (state == STOP) && bit_end && (stop_cnt == STOP_LAST);
    assign pop       = !empty && ((state == IDLE) || frame_end);

    // NOTE: storage has no reset; resetting the pointers and count is enough to discard its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            busy     <= 1'b0;
            shift    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            if (pop) begin
                // Parity is latched from the popped word so later pushes cannot disturb it.
                shift    <= head;
                par_bit  <= (PARITY == 1) ? ~^head : ^head;
                baud_cnt <= '0;
                state    <= START;
                txd      <= 1'b0;
                busy     <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        txd      <= 1'b1;
                        busy     <= 1'b0;
                        baud_cnt <= '0;
                    end
                    START: begin
                        if (bit_end) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            txd     <= shift[0];
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (bit_idx == IDX_LAST) begin
                                if (PARITY != 0) begin
                                    state <= PAR;
                                    txd   <= par_bit;
                                end else begin
                                    state    <= STOP;
                                    stop_cnt <= 1'b0;
                                    txd      <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                shift   <= shift >> 1;
                                txd     <= shift[1];
                            end
                        end
                    end
                    PAR: begin
                        if (bit_end) begin
                            state    <= STOP;
                            stop_cnt <= 1'b0;
                            txd      <= 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            if (stop_cnt == STOP_LAST) begin
                                state <= IDLE;
                                txd   <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                stop_cnt <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four frame formats side by side, each compared every cycle
// against a queue-based model of the FIFO and the expected line waveform.
module tb_uart_tx_fifo;

    logic clk;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // cfg0: 8N1, cfg1: 8E1, cfg2: 7N2, cfg3: 8O1; all with 4 clocks per bit and a 4-deep FIFO.
    for (genvar g = 0; g < 4; g++) begin : gen_cfg
        localparam int C     = 4;
        localparam int DEPTH = 4;
        localparam int DB    = (g == 2) ? 7 : 8;
        localparam int PAR   = (g == 1) ? 2 : (g == 3) ? 1 : 0;
        localparam int STOP  = (g == 2) ? 2 : 1;
        localparam int FRAME = (1 + DB + (PAR != 0 ? 1 : 0) + STOP) * C;
        localparam int NBITS = FRAME / C;
        // Directed words and their line levels, bit 0 = start bit, in transmit order.
        localparam logic [7:0]  W0 = (g == 2) ? 8'h7F : (g == 3) ? 8'h01 : 8'hA5;
        localparam logic [7:0]  W1 = (g == 0) ? 8'h3C : (g == 1) ? 8'h01 : (g == 2) ? 8'h00 : 8'hA5;
        localparam logic [11:0] V0 = (g == 0) ? 12'h34A : (g == 1) ? 12'h54A : (g == 2) ? 12'h3FE : 12'h402;
        localparam logic [11:0] V1 = (g == 0) ? 12'h278 : (g == 1) ? 12'h602 : (g == 2) ? 12'h300 : 12'h74A;

        logic          rst;
        logic          wr_en;
        logic [DB-1:0] wr_data;
        logic          ovf_clr;
        logic          full;
        logic          empty;
        logic [2:0]    count;
        logic          overflow;
        logic          busy;
        logic          txd;
        string         pfx;

        uart_tx_fifo #(
            .CLKS_PER_BIT(C),
            .DATA_BITS   (DB),
            .PARITY      (PAR),
            .STOP_BITS   (STOP),
            .FIFO_DEPTH  (DEPTH)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en),
            .wr_data (wr_data),
            .full    (full),
            .empty   (empty),
            .count   (count),
            .overflow(overflow),
            .ovf_clr (ovf_clr),
            .busy    (busy),
            .txd     (txd)
        );

        // Reference: accepted words wait in q; the frame being sent is a list of per-cycle line levels.
        int unsigned q[$];
        bit          line[$];
        bit          m_ovf = 1'b0;

        initial begin : model
            forever begin
                @(posedge clk or negedge rst);
                if (!rst) begin
                    q.delete();
                    line.delete();
                    m_ovf = 1'b0;
                end else begin
                    bit          was_full;
                    int unsigned w;
                    int          ones;
                    was_full = (q.size() == DEPTH);
                    if (line.size() != 0) void'(line.pop_front());
                    if (line.size() == 0 && q.size() != 0) begin
                        w    = q.pop_front();
                        ones = $countones(w);
                        repeat (C) line.push_back(1'b0);
                        for (int b = 0; b < DB; b++) repeat (C) line.push_back(w[b]);
                        if (PAR == 2) repeat (C) line.push_back(ones % 2 == 1);
                        if (PAR == 1) repeat (C) line.push_back(ones % 2 == 0);
                        repeat (STOP * C) line.push_back(1'b1);
                    end
                    if (wr_en && !was_full) q.push_back(int'(wr_data));
                    if (wr_en && was_full) m_ovf = 1'b1;
                    else if (ovf_clr) m_ovf = 1'b0;
                end
            end
        end

        initial begin : monitor
            forever begin
                @(negedge clk);
                check({pfx, ".txd"},      txd,      (line.size() != 0) ? line[0] : 1'b1);
                check({pfx, ".busy"},     busy,     line.size() != 0);
                check({pfx, ".count"},    count,    q.size());
                check({pfx, ".full"},     full,     q.size() == DEPTH);
                check({pfx, ".empty"},    empty,    q.size() == 0);
                check({pfx, ".overflow"}, overflow, m_ovf);
            end
        end

        task automatic wait_idle(input int budget);
            int i = 0;
            while ((busy || !empty) && i < budget) begin
                @(negedge clk);
                i++;
            end
            check({pfx, ".idle_timeout"}, !busy && empty, 1);
        endtask

        task automatic send_one(input logic [7:0] word, input logic [11:0] levels);
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = DB'(word);
            @(negedge clk);
            wr_en = 1'b0;
            check({pfx, ".lat_push_txd"}, txd, 1);
            @(negedge clk);
            check({pfx, ".lat_pop_txd"}, txd, 0);
            for (int cyc = 0; cyc < FRAME; cyc++) begin
                if (cyc % C == C / 2) check($sformatf("%s.bit%0d", pfx, cyc / C), txd, levels[cyc / C]);
                @(negedge clk);
            end
            check({pfx, ".frame_end_busy"}, busy, 0);
            check({pfx, ".frame_end_empty"}, empty, 1);
        endtask

        task automatic fill_test();
            int exp_cnt[6] = '{1, 1, 2, 3, 4, 4};
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                if (i > 0) check($sformatf("%s.fill_count%0d", pfx, i), count, exp_cnt[i - 1]);
                if (i == 5) check({pfx, ".fill_no_ovf"}, overflow, 0);
                wr_en   = (i < 6);
                wr_data = DB'($urandom);
            end
            check({pfx, ".fill_full"}, full, 1);
            check({pfx, ".fill_ovf"}, overflow, 1);
            wr_en   = 1'b1;
            ovf_clr = 1'b1;
            @(negedge clk);
            check({pfx, ".ovf_set_wins"}, overflow, 1);
            wr_en = 1'b0;
            @(negedge clk);
            check({pfx, ".ovf_cleared"}, overflow, 0);
            ovf_clr = 1'b0;
            wait_idle(6 * FRAME);
        endtask

        task automatic back_to_back_test();
            int busy_cycles = 0;
            for (int cyc = 0; cyc < 4 * FRAME; cyc++) begin
                @(negedge clk);
                busy_cycles += int'(busy);
                wr_en   = (cyc < 3);
                wr_data = DB'($urandom);
            end
            check({pfx, ".b2b_busy_cycles"}, busy_cycles, 3 * FRAME);
        endtask

        task automatic reset_test();
            int  low_cycles = 0;
            bit  busy_seen  = 1'b0;
            for (int cyc = 0; cyc < 4 + 2 * C; cyc++) begin
                @(negedge clk);
                wr_en   = (cyc < 3);
                wr_data = DB'($urandom);
            end
            check({pfx, ".pre_reset_count"}, count, 2);
            #2 rst = 1'b0;
            #1;
            check({pfx, ".async_txd"},   txd,   1);
            check({pfx, ".async_busy"},  busy,  0);
            check({pfx, ".async_count"}, count, 0);
            check({pfx, ".async_empty"}, empty, 1);
            @(negedge clk);
            rst = 1'b1;
            for (int cyc = 0; cyc < 3 * FRAME; cyc++) begin
                @(negedge clk);
                low_cycles += int'(!txd);
                busy_seen  |= busy;
            end
            check({pfx, ".post_reset_low"},  low_cycles, 0);
            check({pfx, ".post_reset_busy"}, busy_seen,  0);
        endtask

        task automatic random_test(input int cycles);
            for (int cyc = 0; cyc < cycles; cyc++) begin
                @(negedge clk);
                wr_en   = ($urandom_range(0, 3) == 0);
                wr_data = DB'($urandom);
                ovf_clr = ($urandom_range(0, 15) == 0);
            end
            @(negedge clk);
            wr_en   = 1'b0;
            ovf_clr = 1'b0;
            wait_idle((DEPTH + 2) * FRAME);
        endtask

        initial begin : stim
            pfx     = $sformatf("cfg%0d", g);
            rst     = 1'b0;
            wr_en   = 1'b0;
            ovf_clr = 1'b0;
            wr_data = '0;
            repeat (3) @(negedge clk);
            check({pfx, ".rst_txd"},      txd,      1);
            check({pfx, ".rst_busy"},     busy,     0);
            check({pfx, ".rst_empty"},    empty,    1);
            check({pfx, ".rst_full"},     full,     0);
            check({pfx, ".rst_count"},    count,    0);
            check({pfx, ".rst_overflow"}, overflow, 0);
            rst = 1'b1;
            send_one(W0, V0);
            send_one(W1, V1);
            fill_test();
            back_to_back_test();
            reset_test();
            random_test(800);
            n_done++;
        end
    end

    initial begin : finish_ctl
        for (int i = 0; i < 60000 && n_done < 4; i++) @(posedge clk);
        if (n_done < 4) check("completion_timeout", n_done, 4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
